mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multi-cycle sequencer for the MIPS datapath: PC, IR, GRF, ALU, DM, EXT, CMP, NPC.
- Replaces the single-cycle combinational Controller.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives per-state write strobes and datapath mux selects. The PC is written exactly once per instruction, in that instruction's final state.

Parameters:
- STATE_W, 3, width of the state encoding.
- RA_IDX, 31, GRF index written by jal.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- opCode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- cmpRes  in  1  CMP equality result (beq taken).
- irWE  out  1  load IR from IM.
- pcWE  out  1  load PC from NPC.
- regWE  out  1  GRF write enable.
- memWE  out  1  DM write enable.
- memMode  out  1  DM access mode (0 = word).
- aluOp  out  3  ALU operation.
- aluSrcMux  out  1  0 = reg2Value, 1 = ext_imm.
- extMode  out  1  0 = zero-extend, 1 = sign-extend.
- regWAMux  out  2  0 = rt, 1 = rd, 2 = $ra.
- regWDMux  out  2  0 = aluRes, 1 = memRD, 2 = PC4.
- npcMode  out  2  0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr.
- state  out  STATE_W  current state, for debug and bench.
- halt  out  1  illegal-instruction halt (see Optional Feature).

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low.
  - While reset = 0: state = FETCH, halt = 0, and irWE/pcWE/regWE/memWE are forced to 0.
  - Mux selects and aluOp are 0 during reset.
  - First FETCH strobe occurs in the first cycle after reset deasserts.
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5. Unused codes go to FETCH next cycle.
- Outputs are combinational from (state, opCode, funct), Moore-style. Only state is registered.
- Decoded classes:
  - RTYPE: op 000000; add funct 100000, sub funct 100010.
  - JR: op 000000, funct 001000.
  - NOP: op 000000, funct 000000.
  - ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, JAL 000011.
- Per-class sequences; "last" marks the state that asserts pcWE:
  - RTYPE: FETCH, DECODE, EXEC, WB(last). regWAMux = 1, regWDMux = 0, aluSrcMux = 0.
  - ORI, LUI: FETCH, DECODE, EXEC, WB(last). regWAMux = 0, aluSrcMux = 1, extMode = 0.
  - LW: FETCH, DECODE, EXEC, MEM, WB(last). extMode = 1, aluOp = ADD, regWDMux = 1.
  - SW: FETCH, DECODE, EXEC, MEM(last). memWE = 1 in MEM.
  - BEQ: FETCH, DECODE, EXEC(last). npcMode = cmpRes ? 1 : 0.
  - JAL: FETCH, DECODE, WB(last). regWAMux = 2, regWDMux = 2, npcMode = 2.
  - JR: FETCH, DECODE(last). npcMode = 3.
  - NOP: FETCH, DECODE(last). npcMode = 0.
- Strobe placement:
  - irWE = 1 only in FETCH.
  - regWE = 1 only in WB.
  - memWE = 1 only in SW's MEM.
  - In every last state except BEQ/JAL/JR, npcMode = 0.
- Selects are held stable across every state of an instruction, because the datapath has no intermediate registers.
- PC is untouched until the last state, so PC4 seen by JAL equals the JAL address + 4.
- Latency: 2 to 5 cycles per instruction, as listed above.
- Illegal opcode/funct without the macro: handled as NOP.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined: an illegal instruction in DECODE moves to HALT. pcWE is 0 in that DECODE. In HALT, halt = 1, all write enables are 0, and the block stays there until reset.
- Undefined: illegal instructions are treated as NOP, HALT is unreachable, and halt is tied to 0.

Decomposition:
- Package mc_pkg holds:
  - state localparams;
  - opcode/funct constants;
  - aluOp codes: ADD = 0, SUB = 1, OR = 2, AND = 3, LUI = 4;
  - npcMode and mux-select codes.
- One sub-module, mc_decode: pure combinational opCode/funct -> instruction class one-hot. Shared with the future hazard unit.
- The FSM and output logic live in mc_controller.

Test Plan:
- Reset: hold reset = 0 for 3 cycles mid-LW (state = MEM) -> state = 0 immediately and all WE = 0. After release: state 0, irWE = 1.
- add $3,$1,$2 (0x00221820) -> states 0,1,2,4. In WB: regWE = 1, regWAMux = 1, aluOp = 0, pcWE = 1. No other cycle has pcWE.
- lw $2,4($1) (0x8C220004) -> 5 cycles; memWE never 1; WB has regWDMux = 1, extMode = 1. Then sw (0xAC220004) -> memWE = 1 and pcWE = 1 in state 3, 4 cycles total.
- beq (0x10220003):
  - cmpRes = 1 -> EXEC has pcWE = 1, npcMode = 1.
  - cmpRes = 0 -> npcMode = 0.
  - 3 cycles each.
- jal (0x0C000C10) -> WB: regWAMux = 2, regWDMux = 2, npcMode = 2. jr $31 (0x03E00008) -> DECODE: pcWE = 1, npcMode = 3, 2 cycles.
- Illegal opcode 0x3F: with MC_ILLEGAL_TRAP_EN -> state 5, halt = 1, no WE for 10 cycles. Without the macro -> 2-cycle NOP, pcWE = 1, npcMode = 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes, ALU and mux codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mc_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_NOP = 6'b000000;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_LUI = 3'd4;

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_JR     = 2'd3;

    localparam logic [1:0] WA_RT = 2'd0;
    localparam logic [1:0] WA_RD = 2'd1;
    localparam logic [1:0] WA_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    localparam logic SRC_REG   = 1'b0;
    localparam logic SRC_IMM   = 1'b1;
    localparam logic EXT_ZERO  = 1'b0;
    localparam logic EXT_SIGN  = 1'b1;
    localparam logic MEM_WORD  = 1'b0;

    // Exactly one field is set per decoded instruction word.
    typedef struct packed {
        logic add;
        logic sub;
        logic jr;
        logic nop;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic illegal;
    } instClass_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier: opCode/funct -> one-hot instruction class.
// Latency: combinational, zero cycles.
// Backpressure: none.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  opCode,
    input  logic [5:0]  funct,
    output instClass_t  cls
);

    always_comb begin
        cls = '0;
        case (opCode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cls.add     = 1'b1;
                    FN_SUB:  cls.sub     = 1'b1;
                    FN_JR:   cls.jr      = 1'b1;
                    FN_NOP:  cls.nop     = 1'b1;
                    default: cls.illegal = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori     = 1'b1;
            OP_LUI:  cls.lui     = 1'b1;
            OP_LW:   cls.lw      = 1'b1;
            OP_SW:   cls.sw      = 1'b1;
            OP_BEQ:  cls.beq     = 1'b1;
            OP_JAL:  cls.jal     = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencer (FETCH/DECODE/EXEC/MEM/WB); MC_ILLEGAL_TRAP_EN sends illegal ops to HALT.
// Latency: 2-5 cycles per instruction; strobes and selects are combinational from state and IR.
// Backpressure: none; the state advances every cycle and PC is written once, in the final state.
module mc_controller #(
    parameter int STATE_W = 3,
    parameter int RA_IDX  = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opCode,
    input  logic [5:0]         funct,
    input  logic               cmpRes,
    output logic               irWE,
    output logic               pcWE,
    output logic               regWE,
    output logic               memWE,
    output logic               memMode,
    output logic [2:0]         aluOp,
    output logic               aluSrcMux,
    output logic               extMode,
    output logic [1:0]         regWAMux,
    output logic [1:0]         regWDMux,
    output logic [1:0]         npcMode,
    output logic [STATE_W-1:0] state,
    output logic               halt
);
    import mc_pkg::*;

    // The $ra index itself is applied by the GRF address mux; only its range matters here.
    if (STATE_W < 3 || RA_IDX < 0 || RA_IDX > 31) begin : gBadParam
        $error("mc_controller: STATE_W must be >= 3 and RA_IDX within 0..31");
    end

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    instClass_t cls;
    logic [2:0] stateQ;
    logic [2:0] stateNext;
    logic       nopLike;
    logic       aluWrite;

    mc_decode uDecode (
        .opCode (opCode),
        .funct  (funct),
        .cls    (cls)
    );

    assign nopLike  = cls.nop | (cls.illegal & ~TRAP);
    assign aluWrite = cls.add | cls.sub | cls.ori | cls.lui;

    always_comb begin
        stateNext = ST_FETCH;
        case (stateQ)
            ST_FETCH:  stateNext = ST_DECODE;
            ST_DECODE: begin
                if (cls.jal)
                    stateNext = ST_WB;
                else if (aluWrite | cls.lw | cls.sw | cls.beq)
                    stateNext = ST_EXEC;
                else if (cls.illegal & TRAP)
                    stateNext = ST_HALT;
                else
                    stateNext = ST_FETCH;
            end
            ST_EXEC: begin
                if (cls.lw | cls.sw)
                    stateNext = ST_MEM;
                else if (aluWrite)
                    stateNext = ST_WB;
                else
                    stateNext = ST_FETCH;
            end
            ST_MEM:    stateNext = cls.lw ? ST_WB : ST_FETCH;
            ST_WB:     stateNext = ST_FETCH;
            ST_HALT:   stateNext = TRAP ? ST_HALT : ST_FETCH;
            default:   stateNext = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stateQ <= ST_FETCH;
        else
            stateQ <= stateNext;
    end

    assign state = STATE_W'(stateQ);

`ifdef MC_ILLEGAL_TRAP_EN
    assign halt = (stateQ == ST_HALT);
`else
    assign halt = 1'b0;
`endif

    // Selects depend only on the instruction, so they hold steady across all its states.
    always_comb begin
        irWE      = 1'b0;
        pcWE      = 1'b0;
        regWE     = 1'b0;
        memWE     = 1'b0;
        memMode   = MEM_WORD;
        aluOp     = ALU_ADD;
        aluSrcMux = SRC_REG;
        extMode   = EXT_ZERO;
        regWAMux  = WA_RT;
        regWDMux  = WD_ALU;
        npcMode   = NPC_PC4;
        if (reset) begin
            if (cls.sub)
                aluOp = ALU_SUB;
            else if (cls.ori)
                aluOp = ALU_OR;
            else if (cls.lui)
                aluOp = ALU_LUI;
            aluSrcMux = (cls.ori | cls.lui | cls.lw | cls.sw) ? SRC_IMM : SRC_REG;
            extMode   = (cls.lw | cls.sw | cls.beq) ? EXT_SIGN : EXT_ZERO;
            if (cls.add | cls.sub)
                regWAMux = WA_RD;
            else if (cls.jal)
                regWAMux = WA_RA;
            if (cls.lw)
                regWDMux = WD_MEM;
            else if (cls.jal)
                regWDMux = WD_PC4;
            if (cls.jr)
                npcMode = NPC_JR;
            else if (cls.jal)
                npcMode = NPC_JUMP;
            else if (cls.beq && cmpRes)
                npcMode = NPC_BRANCH;

            case (stateQ)
                ST_FETCH:  irWE = 1'b1;
                ST_DECODE: pcWE = cls.jr | nopLike;
                ST_EXEC:   pcWE = cls.beq;
                ST_MEM: begin
                    memWE = cls.sw;
                    pcWE  = cls.sw;
                end
                ST_WB: begin
                    regWE = 1'b1;
                    pcWE  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed program plus random instruction stream against a sequence-table model.
// Build with MC_ILLEGAL_TRAP_EN to exercise the HALT trap.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opCode = '0;
    logic [5:0] funct = '0;
    logic       cmpRes = 1'b0;
    logic       irWE, pcWE, regWE, memWE, memMode, aluSrcMux, extMode, halt;
    logic [2:0] aluOp;
    logic [1:0] regWAMux, regWDMux, npcMode;
    logic [2:0] state;

    mc_controller #(.STATE_W(3), .RA_IDX(31)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .funct(funct), .cmpRes(cmpRes),
        .irWE(irWE), .pcWE(pcWE), .regWE(regWE), .memWE(memWE), .memMode(memMode),
        .aluOp(aluOp), .aluSrcMux(aluSrcMux), .extMode(extMode), .regWAMux(regWAMux),
        .regWDMux(regWDMux), .npcMode(npcMode), .state(state), .halt(halt)
    );

    always #5 clk = ~clk;

`ifdef MC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef enum int {K_ADD, K_SUB, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_JAL, K_JR, K_NOP, K_ILL} kind_t;

    int checks = 0;
    int errors = 0;
    int pcPulses = 0;

    bit expVld = 1'b0;
    int eState, eIr, ePc, eReg, eMem, eHalt, eAlu, eWA, eWD, eSrc, eExt, eNpc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction lengths and state walks, straight from the per-class sequence list.
    function automatic int seqLen(kind_t k);
        case (k)
            K_ADD, K_SUB, K_ORI, K_LUI, K_SW: return 4;
            K_LW:                             return 5;
            K_BEQ, K_JAL:                     return 3;
            default:                          return 2;
        endcase
    endfunction

    function automatic int pathState(kind_t k, int i);
        int p[5];
        case (k)
            K_ADD, K_SUB, K_ORI, K_LUI: p = '{0, 1, 2, 4, 0};
            K_LW:                       p = '{0, 1, 2, 3, 4};
            K_SW:                       p = '{0, 1, 2, 3, 0};
            K_BEQ:                      p = '{0, 1, 2, 0, 0};
            K_JAL:                      p = '{0, 1, 4, 0, 0};
            default:                    p = '{0, 1, 0, 0, 0};
        endcase
        return p[i];
    endfunction

    function automatic logic [31:0] makeIr(kind_t k);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_ADD: return {6'h00, r[25:11], 5'h00, 6'h20};
            K_SUB: return {6'h00, r[25:11], 5'h00, 6'h22};
            K_ORI: return {6'h0D, r[25:0]};
            K_LUI: return {6'h0F, r[25:0]};
            K_LW:  return {6'h23, r[25:0]};
            K_SW:  return {6'h2B, r[25:0]};
            K_BEQ: return {6'h04, r[25:0]};
            K_JAL: return {6'h03, r[25:0]};
            K_JR:  return {6'h00, r[25:21], 15'h0, 6'h08};
            K_NOP: return 32'h0000_0000;
            default: begin
                case ($urandom_range(0, 2))
                    0:       return {6'h3F, r[25:0]};
                    1:       return {6'h02, r[25:0]};
                    default: return {6'h00, r[25:6], 6'h2A};
                endcase
            end
        endcase
    endfunction

    task automatic setExp(input kind_t k, input int i, input bit cmp);
        int len;
        len    = seqLen(k);
        eState = pathState(k, i);
        eIr    = (i == 0) ? 1 : 0;
        ePc    = (i == len - 1) ? 1 : 0;
        eReg   = (eState == 4) ? 1 : 0;
        eMem   = (k == K_SW && eState == 3) ? 1 : 0;
        eHalt  = 0;
        eAlu = -1; eWA = -1; eWD = -1; eSrc = -1; eExt = -1; eNpc = -1;
        if (i > 0) begin
            case (k)
                K_ADD: begin eAlu = 0; eWA = 1; eWD = 0; eSrc = 0; end
                K_SUB: begin eAlu = 1; eWA = 1; eWD = 0; eSrc = 0; end
                K_ORI, K_LUI: begin eWA = 0; eWD = 0; eSrc = 1; eExt = 0; end
                K_LW:  begin eAlu = 0; eWA = 0; eWD = 1; eExt = 1; end
                K_JAL: begin eWA = 2; eWD = 2; end
                default: ;
            endcase
        end
        if (i == len - 1) begin
            case (k)
                K_BEQ:   eNpc = cmp ? 1 : 0;
                K_JAL:   eNpc = 2;
                K_JR:    eNpc = 3;
                default: eNpc = 0;
            endcase
        end
    endtask

    // Entered just after a rising edge with the DUT in FETCH; leaves just after a rising edge.
    task automatic runInstr(input kind_t k, input logic [31:0] ir, input bit cmp, input int steps);
        int n;
        opCode = ir[31:26];
        funct  = ir[5:0];
        cmpRes = cmp;
        n = (steps < 0) ? seqLen(k) : steps;
        for (int i = 0; i < n; i++) begin
            setExp(k, i, cmp);
            expVld = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (pcWE === 1'b1)
                pcPulses++;
            if (expVld) begin
                chk("state", int'(state), eState);
                chk("irWE", int'(irWE), eIr);
                chk("pcWE", int'(pcWE), ePc);
                chk("regWE", int'(regWE), eReg);
                chk("memWE", int'(memWE), eMem);
                chk("halt", int'(halt), eHalt);
                chk("memMode", int'(memMode), 0);
                if (eAlu >= 0) chk("aluOp", int'(aluOp), eAlu);
                if (eWA >= 0)  chk("regWAMux", int'(regWAMux), eWA);
                if (eWD >= 0)  chk("regWDMux", int'(regWDMux), eWD);
                if (eSrc >= 0) chk("aluSrcMux", int'(aluSrcMux), eSrc);
                if (eExt >= 0) chk("extMode", int'(extMode), eExt);
                if (eNpc >= 0) chk("npcMode", int'(npcMode), eNpc);
            end
        end
    end

    initial begin
        int p0;
        kind_t k;
        // Model pins: lengths hand-taken from the sequence list.
        chk("model len add", seqLen(K_ADD), 4);
        chk("model len lw", seqLen(K_LW), 5);
        chk("model len jal", seqLen(K_JAL), 3);
        chk("model jal last state", pathState(K_JAL, 2), 4);
        chk("model sw last state", pathState(K_SW, 3), 3);

        repeat (3) @(posedge clk);
        #1;
        chk("rst state", int'(state), 0);
        chk("rst irWE", int'(irWE), 0);
        chk("rst pcWE", int'(pcWE), 0);
        chk("rst halt", int'(halt), 0);
        reset = 1'b1;
        #1;
        chk("post-rst state", int'(state), 0);
        chk("post-rst irWE", int'(irWE), 1);

        p0 = pcPulses;
        runInstr(K_ADD, 32'h0022_1820, 1'b0, -1);
        chk("add pcWE count", pcPulses - p0, 1);
        runInstr(K_LW, 32'h8C22_0004, 1'b0, -1);
        p0 = pcPulses;
        runInstr(K_SW, 32'hAC22_0004, 1'b0, -1);
        chk("sw pcWE count", pcPulses - p0, 1);
        runInstr(K_BEQ, 32'h1022_0003, 1'b1, -1);
        runInstr(K_BEQ, 32'h1022_0003, 1'b0, -1);
        runInstr(K_JAL, 32'h0C00_0C10, 1'b0, -1);
        p0 = pcPulses;
        runInstr(K_JR, 32'h03E0_0008, 1'b0, -1);
        chk("jr pcWE count", pcPulses - p0, 1);

        // Reset asserted while an lw sits in MEM.
        runInstr(K_LW, 32'h8C22_0004, 1'b0, 3);
        expVld = 1'b0;
        chk("lw in MEM", int'(state), 3);
        reset = 1'b0;
        #1;
        chk("async rst state", int'(state), 0);
        chk("async rst memWE", int'(memWE), 0);
        chk("async rst regWE", int'(regWE), 0);
        chk("async rst regWDMux", int'(regWDMux), 0);
        chk("async rst extMode", int'(extMode), 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("held rst state", int'(state), 0);
            chk("held rst irWE", int'(irWE), 0);
            chk("held rst pcWE", int'(pcWE), 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("release state", int'(state), 0);
        chk("release irWE", int'(irWE), 1);

        for (int n = 0; n < 300; n++) begin
            k = kind_t'($urandom_range(0, TRAP ? 9 : 10));
            runInstr(k, makeIr(k), 1'($urandom_range(0, 1)), -1);
        end

`ifdef MC_ILLEGAL_TRAP_EN
        opCode = 6'h3F;
        funct  = 6'h00;
        setExp(K_NOP, 0, 1'b0);
        expVld = 1'b1;
        @(posedge clk);
        #1;
        setExp(K_NOP, 1, 1'b0);
        ePc = 0;
        eNpc = -1;
        @(posedge clk);
        #1;
        eState = 5; eIr = 0; ePc = 0; eReg = 0; eMem = 0; eHalt = 1;
        repeat (10) @(posedge clk);
        #1;
        expVld = 1'b0;
        reset = 1'b0;
        #1;
        chk("trap rst state", int'(state), 0);
        chk("trap rst halt", int'(halt), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("trap release irWE", int'(irWE), 1);
`else
        p0 = pcPulses;
        runInstr(K_ILL, 32'hFC00_0000, 1'b0, -1);
        chk("illegal pcWE count", pcPulses - p0, 1);
        chk("illegal halt", int'(halt), 0);
`endif
        expVld = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
